char_shifter: RTL and testbench

Character-layer video serializer sitting directly downstream of the cascaded 74163 horizontal/vertical beam counters. Each 8-pixel cell, it samples the counter outputs and fetches the tile code from video RAM. It then fetches the matching character-ROM row, holds it in a pending register and parallel-loads it into an 8-bit shifter. The shifter emits one registered pixel per pixel-clock enable, with blanking delayed to match. Its output feeds the colour/palette stage.

---
 rtl/char_shifter.sv | 104 ++++++++++
 tb/tb_char_shifter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/char_shifter.sv
// Character-layer serializer: per 8-pixel cell, fetches tile code and char-ROM row, then shifts pixels out.
// Optional screen flip is compiled in with `define CHAR_SHIFTER_FLIP_EN.
module char_shifter #(
  parameter int BLANK_DELAY = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [8:0]  hcnt,
  input  logic [7:0]  vcnt,
  input  logic        hblank,
  input  logic        vblank,
  input  logic        flip,
  output logic [9:0]  vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        pixel,
  output logic        blank
);

  logic [2:0]             phase;
  logic [4:0]             tile_col;
  logic [4:0]             tile_row;
  logic [2:0]             line;
  logic [7:0]             load_val;
  logic [7:0]             tile_p1;
  logic [7:0]             pend_p3;
  logic [7:0]             shift_p7;
  logic [7:0]             shift_next;
  logic [BLANK_DELAY-1:0] blank_pipe;
  logic                   blank_tail;

  assign phase = hcnt[2:0];

`ifdef CHAR_SHIFTER_FLIP_EN
  function automatic logic [7:0] bit_rev(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  logic unused_hcnt_msb;
  assign unused_hcnt_msb = hcnt[8];

  assign tile_col = flip ? ~hcnt[7:3] : hcnt[7:3];
  assign tile_row = flip ? ~vcnt[7:3] : vcnt[7:3];
  assign line     = flip ? ~vcnt[2:0] : vcnt[2:0];
  // Reversed load makes the rightmost ROM pixel leave the MSB first.
  assign load_val = flip ? bit_rev(pend_p3) : pend_p3;
`else
  logic unused_inputs;
  assign unused_inputs = &{1'b1, flip, hcnt[8]};

  assign tile_col = hcnt[7:3];
  assign tile_row = vcnt[7:3];
  assign line     = vcnt[2:0];
  assign load_val = pend_p3;
`endif

  // Fetch schedule: address, tile, ROM address, pending row
  always_ff @(posedge clk) begin
    if (reset) begin
      vram_addr <= '0;
      vram_rd   <= 1'b0;
      tile_p1   <= '0;
      rom_addr  <= '0;
      pend_p3   <= '0;
    end else if (ce) begin
      vram_rd <= (phase == 3'd0);
      case (phase)
        3'd0:    vram_addr <= {tile_row, tile_col};
        3'd1:    tile_p1   <= vram_data;
        3'd2:    rom_addr  <= {tile_p1, line};
        3'd3:    pend_p3   <= rom_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    shift_next = {shift_p7[6:0], 1'b0};
    if (phase == 3'd7) shift_next = load_val;
  end

  assign blank_tail = blank_pipe[BLANK_DELAY-1];

  // Serializer and blank delay; the shifter keeps running through blanking
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_p7   <= '0;
      blank_pipe <= '0;
      pixel      <= 1'b0;
      blank      <= 1'b0;
    end else if (ce) begin
      shift_p7   <= shift_next;
      blank_pipe <= {blank_pipe[BLANK_DELAY-2:0], hblank | vblank};
      pixel      <= shift_next[7] & ~blank_tail;
      blank      <= blank_tail;
    end
  end

endmodule

// File: tb/tb_char_shifter.sv
// Bench for char_shifter: table of line segments driven through a beam-position scoreboard,
// with memories modelled combinationally from the DUT addresses.
module tb_char_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic [8:0]  hcnt = '0;
  logic [7:0]  vcnt = '0;
  logic        hblank = 1'b0;
  logic        vblank = 1'b0;
  logic        flip = 1'b0;
  logic [9:0]  vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        pixel;
  logic        blank;

  always #5 clk = ~clk;

  char_shifter #(.BLANK_DELAY(7)) dut (
    .clk(clk), .reset(reset), .ce(ce), .hcnt(hcnt), .vcnt(vcnt),
    .hblank(hblank), .vblank(vblank), .flip(flip),
    .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_data(vram_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .pixel(pixel), .blank(blank)
  );

`ifdef CHAR_SHIFTER_FLIP_EN
  localparam bit FLIP_BUILT = 1'b1;
`else
  localparam bit FLIP_BUILT = 1'b0;
`endif

  bit         use_const = 1'b0;
  logic [7:0] vc = '0;
  logic [7:0] rc = '0;

  function automatic logic [7:0] vfun(input logic [9:0] a);
    return a[7:0] ^ {a[9:8], 6'h25};
  endfunction

  function automatic logic [7:0] rfun(input logic [10:0] a);
    logic [7:0] t;
    t = a[10:3] * 8'd13;
    return t ^ {a[2:0], 5'h0B};
  endfunction

  always_comb begin
    vram_data = use_const ? vc : vfun(vram_addr);
    rom_data  = use_const ? rc : rfun(rom_addr);
  end

  function automatic logic [7:0] memv(input logic [9:0] a);
    return use_const ? vc : vfun(a);
  endfunction

  function automatic logic [7:0] memr(input logic [10:0] a);
    return use_const ? rc : rfun(a);
  endfunction

  typedef struct packed { logic pix; logic blk; } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0]  m_vaddr;
  logic [7:0]  m_tile;
  logic [10:0] m_raddr;
  logic        m_rd, m_pix, m_blk;
  bit          cell_ok;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    for (int k = 0; k < 7; k++) sb.push_back('0);
    m_vaddr = '0; m_tile = '0; m_raddr = '0;
    m_rd = 1'b0; m_pix = 1'b0; m_blk = 1'b0; cell_ok = 1'b0;
  endtask

  task automatic step(input bit r, input bit c, input logic [8:0] h, input logic [7:0] v,
                      input bit hb, input bit vb, input bit f);
    logic [2:0] ph, row, idx;
    logic [4:0] col, vr;
    logic [7:0] bits;
    bit         ef;
    exp_t       e, x;
    reset = r; ce = c; hcnt = h; vcnt = v; hblank = hb; vblank = vb; flip = f;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else if (c) begin
      ef  = f & FLIP_BUILT;
      ph  = h[2:0];
      col = ef ? ~h[7:3] : h[7:3];
      vr  = ef ? ~v[7:3] : v[7:3];
      row = ef ? ~v[2:0] : v[2:0];
      m_rd = (ph == 3'd0);
      if (ph == 3'd0) begin
        m_vaddr = {vr, col};
        cell_ok = 1'b1;
      end
      if (ph == 3'd1) m_tile = memv(m_vaddr);
      if (ph == 3'd2) m_raddr = {m_tile, row};
      bits  = memr({memv({vr, col}), row});
      idx   = ef ? ph : 3'd7 - ph;
      e.blk = hb | vb;
      e.pix = cell_ok & bits[idx] & ~e.blk;
      sb.push_back(e);
      if (sb.size() >= 8) begin
        x = sb.pop_front();
        m_pix = x.pix;
        m_blk = x.blk;
      end
    end
    check("vram_rd", 16'(vram_rd), 16'(m_rd));
    check("vram_addr", 16'(vram_addr), 16'(m_vaddr));
    check("rom_addr", 16'(rom_addr), 16'(m_raddr));
    check("pixel", 16'(pixel), 16'(m_pix));
    check("blank", 16'(blank), 16'(m_blk));
  endtask

  typedef struct {
    int         start_h;
    int         len;
    logic [7:0] v;
    int         lo;
    int         hi;
    bit         vb;
    bit         uc;
    logic [7:0] vconst;
    logic [7:0] rconst;
    int         gate_at;
    int         rst_at;
    bit         fl;
  } run_t;

  run_t runs[6];

  initial begin
    logic [7:0] seq;
    logic [8:0] h;
    bit         act;
    runs[0] = '{0,   16, 8'h0A, -1, -2, 1'b0, 1'b1, 8'h41, 8'hA5, -1, -1, 1'b0};
    runs[1] = '{0,   24, 8'h0A,  0,  3, 1'b0, 1'b1, 8'h41, 8'hFF, -1, -1, 1'b0};
    runs[2] = '{0,   32, 8'h33, -1, -2, 1'b0, 1'b0, 8'h00, 8'h00, 11, -1, 1'b0};
    runs[3] = '{248, 24, 8'h7F,  4,  9, 1'b1, 1'b0, 8'h00, 8'h00, -1, -1, 1'b0};
    runs[4] = '{0,   40, 8'hC5, 17, 22, 1'b0, 1'b0, 8'h00, 8'h00, -1, -1, 1'b1};
    runs[5] = '{0,   40, 8'h12, -1, -2, 1'b0, 1'b0, 8'h00, 8'h00, -1, 12, 1'b0};
    seq = 8'b10100101;
    model_reset();

    for (int r = 0; r < 6; r++) begin
      use_const = runs[r].uc;
      vc = runs[r].vconst;
      rc = runs[r].rconst;
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 9'd0, runs[r].v, 1'b0, 1'b0, runs[r].fl);
      if (r == 0) begin
        check("reset_pixel", 16'(pixel), 16'd0);
        check("reset_blank", 16'(blank), 16'd0);
        check("reset_vram_rd", 16'(vram_rd), 16'd0);
        check("reset_vram_addr", 16'(vram_addr), 16'd0);
        check("reset_rom_addr", 16'(rom_addr), 16'd0);
      end
      for (int i = 0; i < runs[r].len; i++) begin
        h   = 9'(runs[r].start_h + i);
        act = (i >= runs[r].lo) && (i <= runs[r].hi);
        if (i == runs[r].gate_at) begin
          for (int k = 0; k < 5; k++)
            step(1'b0, 1'b0, 9'($urandom_range(0, 511)), runs[r].v,
                 1'($urandom_range(0, 1)), 1'b0, runs[r].fl);
        end
        step(i == runs[r].rst_at, 1'b1, h, runs[r].v,
             act & ~runs[r].vb, act & runs[r].vb, runs[r].fl);
        if (r == 0 && i == 0) check("cell_vram_addr", 16'(vram_addr), 16'h020);
        if (r == 0 && i == 2) check("cell_rom_addr", 16'(rom_addr), 16'h20A);
        if (r == 0 && i >= 7 && i <= 14) check("cell_pixel_seq", 16'(pixel), 16'(seq[14-i]));
        if (r == 1 && i >= 7 && i <= 10) begin
          check("blank_aligned", 16'(blank), 16'd1);
          check("blank_masks_pixel", 16'(pixel), 16'd0);
        end
        if (r == 1 && i == 11) check("unblank_pixel", 16'(pixel), 16'd1);
        if (r == 3 && i == 0) check("wrap_col31", 16'(vram_addr), 16'({5'h0F, 5'd31}));
        if (r == 3 && i == 8) check("wrap_col0", 16'(vram_addr), 16'({5'h0F, 5'd0}));
        if (r == 5 && i > 12 && i <= 22) check("reset_midline_pixel", 16'(pixel), 16'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
